io_instr_seq: RTL and testbench
===============================

# io_instr_seq

Instruction-level sequencer for Z80 I/O instructions: IN A,(n), IN r,(C), OUT (n),A, OUT (C),r and the block forms INI/IND/INIR/INDR/OUTI/OUTD/OTIR/OTDR. It sits directly upstream of the non-M1 I/O bus-cycle module. It forms the port address and write data, fires one I/O bus cycle per transfer, and for block forms interleaves a memory cycle through the memory-cycle port. It returns read data, updated B/HL and flags to the register file.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on posedge.
- nRESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- op  in  2  0=IN (n), 1=IN (C), 2=OUT (n), 3=OUT (C); with blk=1, only bit 1 matters: 0=block in, 1=block out.
- blk, dec, rep  in  1 each  block form; HL decrement (else increment); repeat until B=0.
- a_in, n_in, wval_in, f_in  in  8 each  A, immediate n, register value for OUT (C),r, current F.
- bc_in, hl_in  in  16 each  BC, HL at start.
- io_activate  out  1  one-cycle pulse to the I/O bus-cycle module.
- io_rd, io_wr  out  1 each  cycle type; exactly one high while an I/O cycle is outstanding.
- io_addr  out  16  port address.
- io_wdata  out  8  port write data.
- io_rdata  in  8  port read data; valid on the cycle io_done is sampled high.
- io_done  in  1  one-cycle completion from the I/O bus-cycle module.
- mem_req  out  1  one-cycle memory request pulse.
- mem_wr  out  1  memory cycle type.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data.
- mem_done  in  1  one-cycle memory completion.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  byte read by IN forms.
- b_out  out  8  updated B.
- hl_out  out  16  updated HL.
- f_out  out  8  new F, valid with done.
- f_we  out  1  high with done when F is to be written; low for IN (n) and OUT forms except block out.

## Operation
- States: IDLE, IO_GO, IO_WAIT, MEM_GO, MEM_WAIT, UPD, FIN.
- IDLE + start: latch all inputs → IO_GO (IN/OUT, block in) or MEM_GO (block out).
- IO_GO: pulse io_activate for exactly 1 cycle → IO_WAIT.
- While a cycle is outstanding, io_addr, io_rd, io_wr and io_wdata hold stable until io_done.
- Port address:
  - (n) forms: {A, n}.
  - (C) forms and block in: {B, C}, using B before decrement.
  - Block out: {B−1, C}, using B after decrement.
- io_wdata: A for OUT (n); wval for OUT (C); the memory byte for block out.
- IO_WAIT + io_done: capture io_rdata.
  - Block in → MEM_GO, memory write of the captured byte to HL.
  - Block out → UPD.
  - Otherwise → FIN.
- MEM_GO: pulse mem_req for 1 cycle, with address and data held → MEM_WAIT.
- MEM_WAIT + mem_done:
  - Block in → UPD.
  - Block out: capture mem_rdata, B←B−1 mod 256 → IO_GO.
- UPD:
  - Block in: B←B−1 mod 256.
  - HL←HL±1 mod 65536.
  - If rep and B≠0 → next iteration (IO_GO or MEM_GO); else → FIN.
- FIN: done=1, busy=0 next cycle → IDLE.
- Flags:
  - IN (C): S=r[7], Z=(r==0), H=0, P/V=even parity of r, N=0, bits 5/3 = r[5]/r[3], C=f_in[0].
  - Block forms: Z=(B_out==0), S=B_out[7], N=1, other bits = f_in.

## Timing
- Reset, asynchronous: state IDLE. All outputs 0, including io_activate, io_rd, io_wr, mem_req, busy, done, f_we, addresses and data.
- Reset mid-operation aborts immediately; no further pulses are issued.
- start→io_activate: 1 cycle. io_done→done for single forms: 2 cycles (IO_WAIT→FIN, done registered).
- Block iteration overhead: 1 UPD cycle plus 1 issue cycle per bus cycle.
- io_activate and mem_req are never high together.
- A new io_activate is never issued in the cycle io_done is sampled, so the downstream block cannot double-start.
- start while busy is ignored.
- rep with B=0 at start performs 256 iterations (B wraps to 0xFF).
- HL wraps: 0xFFFF+1=0x0000, 0x0000−1=0xFFFF.

## Test plan
- IN A,(0x34), A=0x12, port returns 0xFE -> io_addr=0x1234, io_rd=1, rdata=0xFE, f_we=0, done 2 cycles after io_done.
- IN r,(C), BC=0x5678, port returns 0x00 -> io_addr=0x5678, f_out Z=1, P/V=1, N=0, H=0, C=f_in[0].
- OUT (C),r, BC=0x0110, wval=0x67, downstream wait states inserted -> io_wr=1, io_wdata=0x67, io_addr stable until io_done, single done.
- INIR, B=2, C=0x10, HL=0x4000 -> I/O addresses 0x0210 then 0x0110; memory writes to 0x4000 and 0x4001; B_out=0, HL_out=0x4002, Z=1, N=1.
- OTDR, B=1, C=0x20, HL=0x0000, memory byte 0xA5 -> memory read at 0x0000, io_addr=0x0020, io_wdata=0xA5, HL_out=0xFFFF, Z=1.
- nRESET asserted during IO_WAIT of INIR -> all outputs 0 asynchronously; after release, no io_activate until a new start.

Source files
------------

// File: rtl/io_instr_seq.sv
// Z80 I/O instruction sequencer: issues the port cycle for IN/OUT and, for the block forms, the
// interleaved memory cycle, then returns read data, updated B/HL and flags to the register file.
module io_instr_seq (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        blk,
    input  logic        dec,
    input  logic        rep,
    input  logic [7:0]  a_in,
    input  logic [7:0]  n_in,
    input  logic [7:0]  wval_in,
    input  logic [7:0]  f_in,
    input  logic [15:0] bc_in,
    input  logic [15:0] hl_in,
    output logic        io_activate,
    output logic        io_rd,
    output logic        io_wr,
    output logic [15:0] io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_done,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_done,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [7:0]  b_out,
    output logic [15:0] hl_out,
    output logic [7:0]  f_out,
    output logic        f_we
);

    typedef enum logic [2:0] {
        S_IDLE, S_IO_GO, S_IO_WAIT, S_MEM_GO, S_MEM_WAIT, S_UPD, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic        blk_q, dec_q, rep_q;
    logic [7:0]  a_q, n_q, wval_q, f_q, c_q;
    logic [7:0]  b_q, b_d;
    logic [15:0] hl_q, hl_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  rdata_q, b_out_q, f_out_q;
    logic [15:0] hl_out_q;
    logic        done_q, f_we_q;

    logic        is_in, blk_in, blk_out, in_c, io_cycle, mem_cycle, load;
    logic [7:0]  in_c_flags, blk_flags;

    assign load      = (state_q == S_IDLE) && start;
    assign is_in     = ~op_q[1];
    assign blk_in    = blk_q & is_in;
    assign blk_out   = blk_q & op_q[1];
    assign in_c      = ~blk_q & is_in & op_q[0];
    assign io_cycle  = (state_q == S_IO_GO) || (state_q == S_IO_WAIT);
    assign mem_cycle = (state_q == S_MEM_GO) || (state_q == S_MEM_WAIT);

    // Flag layout: S Z 5 H 3 P/V N C
    assign in_c_flags = {data_q[7], data_q == 8'h00, data_q[5], 1'b0, data_q[3], ~^data_q, 1'b0, f_q[0]};
    assign blk_flags  = {b_q[7], b_q == 8'h00, f_q[5:2], 1'b1, f_q[0]};

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        hl_d    = hl_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d     = bc_in[15:8];
                    hl_d    = hl_in;
                    data_d  = 8'h00;
                    state_d = (blk && op[1]) ? S_MEM_GO : S_IO_GO;
                end
            end
            S_IO_GO: state_d = S_IO_WAIT;
            S_IO_WAIT: begin
                if (io_done) begin
                    // OUT forms keep data_q: for block out it holds the memory byte being sent.
                    if (is_in) data_d = io_rdata;
                    if (blk_in)       state_d = S_MEM_GO;
                    else if (blk_out) state_d = S_UPD;
                    else              state_d = S_FIN;
                end
            end
            S_MEM_GO: state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (mem_done) begin
                    if (blk_out) begin
                        data_d  = mem_rdata;
                        b_d     = b_q - 8'd1;
                        state_d = S_IO_GO;
                    end else begin
                        state_d = S_UPD;
                    end
                end
            end
            S_UPD: begin
                if (blk_in) b_d = b_q - 8'd1;
                hl_d = dec_q ? hl_q - 16'd1 : hl_q + 16'd1;
                if (rep_q && (b_d != 8'h00)) state_d = blk_in ? S_IO_GO : S_MEM_GO;
                else                         state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            op_q     <= 2'd0;
            blk_q    <= 1'b0;
            dec_q    <= 1'b0;
            rep_q    <= 1'b0;
            a_q      <= 8'h00;
            n_q      <= 8'h00;
            wval_q   <= 8'h00;
            f_q      <= 8'h00;
            c_q      <= 8'h00;
            b_q      <= 8'h00;
            hl_q     <= 16'h0000;
            data_q   <= 8'h00;
            rdata_q  <= 8'h00;
            b_out_q  <= 8'h00;
            hl_out_q <= 16'h0000;
            f_out_q  <= 8'h00;
            done_q   <= 1'b0;
            f_we_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            hl_q    <= hl_d;
            data_q  <= data_d;
            if (load) begin
                op_q   <= op;
                blk_q  <= blk;
                dec_q  <= dec;
                rep_q  <= rep;
                a_q    <= a_in;
                n_q    <= n_in;
                wval_q <= wval_in;
                f_q    <= f_in;
                c_q    <= bc_in[7:0];
            end
            done_q <= (state_q == S_FIN);
            f_we_q <= (state_q == S_FIN) && (blk_q || in_c);
            if (state_q == S_FIN) begin
                rdata_q  <= data_q;
                b_out_q  <= b_q;
                hl_out_q <= hl_q;
                f_out_q  <= blk_q ? blk_flags : (in_c ? in_c_flags : f_q);
            end
        end
    end

    // Bus outputs are qualified by state so they read zero whenever no cycle is outstanding.
    assign io_activate = (state_q == S_IO_GO);
    assign io_rd       = io_cycle & is_in;
    assign io_wr       = io_cycle & op_q[1];
    assign io_addr     = !io_cycle ? 16'h0000 :
                         (!blk_q && !op_q[0]) ? {a_q, n_q} : {b_q, c_q};
    assign io_wdata    = !(io_cycle && op_q[1]) ? 8'h00 :
                         blk_q ? data_q : (op_q[0] ? wval_q : a_q);

    assign mem_req   = (state_q == S_MEM_GO);
    assign mem_wr    = mem_cycle & blk_in;
    assign mem_addr  = mem_cycle ? hl_q : 16'h0000;
    assign mem_wdata = (mem_cycle && blk_in) ? data_q : 8'h00;

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign b_out  = b_out_q;
    assign hl_out = hl_out_q;
    assign f_out  = f_out_q;
    assign f_we   = f_we_q;

endmodule

// File: tb/tb_io_instr_seq.sv
// Scoreboard bench for io_instr_seq: directed IN/OUT/block sequences with I/O and memory responders.
module tb_io_instr_seq;

    localparam int K_IO   = 0;
    localparam int K_MEM  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  data;
        logic        chk;
        logic [7:0]  b;
        logic [15:0] hl;
        logic [7:0]  f;
        logic        fwe;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic        blk = 1'b0, dec = 1'b0, rep = 1'b0;
    logic [7:0]  a_in = 8'h00, n_in = 8'h00, wval_in = 8'h00, f_in = 8'h00;
    logic [15:0] bc_in = 16'h0000, hl_in = 16'h0000;
    logic        io_activate, io_rd, io_wr;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata = 8'h00;
    logic        io_done = 1'b0;
    logic        mem_req, mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_done = 1'b0;
    logic        busy, done;
    logic [7:0]  rdata, b_out, f_out;
    logic [15:0] hl_out;
    logic        f_we;

    io_instr_seq dut (
        .clk(clk), .nRESET(nRESET), .start(start), .op(op), .blk(blk), .dec(dec), .rep(rep),
        .a_in(a_in), .n_in(n_in), .wval_in(wval_in), .f_in(f_in), .bc_in(bc_in), .hl_in(hl_in),
        .io_activate(io_activate), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_done(io_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .busy(busy), .done(done), .rdata(rdata), .b_out(b_out), .hl_out(hl_out),
        .f_out(f_out), .f_we(f_we)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    io_done_cyc = 0;
    int    act_cnt = 0;
    int    io_wait = 0;
    string test_name = "reset";
    exp_t  exp_q[$];
    logic [7:0] io_data_q[$];
    logic [7:0] mem_data_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", test_name, name, act, exp);
        end
    endtask

    task automatic push_io(input logic [15:0] addr, input logic rd, input logic wr, input logic [7:0] d);
        exp_t e;
        e = '{kind: K_IO, addr: addr, rd: rd, wr: wr, data: d, chk: wr, b: 8'h00, hl: 16'h0000,
              f: 8'h00, fwe: 1'b0, lat: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input logic [15:0] addr, input logic wr, input logic [7:0] d);
        exp_t e;
        e = '{kind: K_MEM, addr: addr, rd: ~wr, wr: wr, data: d, chk: wr, b: 8'h00, hl: 16'h0000,
              f: 8'h00, fwe: 1'b0, lat: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [7:0] rd, input logic chk, input logic [7:0] b,
                             input logic [15:0] hl, input logic [7:0] f, input logic fwe, input int lat);
        exp_t e;
        e = '{kind: K_DONE, addr: 16'h0000, rd: 1'b0, wr: 1'b0, data: rd, chk: chk, b: b, hl: hl,
              f: f, fwe: fwe, lat: lat};
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per DUT-presented event and compares.
    exp_t m;
    always @(negedge clk) begin
        if (nRESET) begin
            if (io_done) io_done_cyc = cyc;
            if (io_activate || mem_req) check("no_overlap", io_activate & mem_req, 1'b0);
            if (io_activate || mem_req || done) begin
                check("event_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    m = exp_q.pop_front();
                    if (io_activate) begin
                        act_cnt++;
                        check("io_kind", m.kind, K_IO);
                        check("io_addr", io_addr, m.addr);
                        check("io_rdwr", {io_rd, io_wr}, {m.rd, m.wr});
                        if (m.chk) check("io_wdata", io_wdata, m.data);
                    end else if (mem_req) begin
                        check("mem_kind", m.kind, K_MEM);
                        check("mem_addr", mem_addr, m.addr);
                        check("mem_wr", mem_wr, m.wr);
                        if (m.chk) check("mem_wdata", mem_wdata, m.data);
                    end else begin
                        check("done_kind", m.kind, K_DONE);
                        check("done_busy", busy, 1'b0);
                        if (m.chk) check("rdata", rdata, m.data);
                        check("b_out", b_out, m.b);
                        check("hl_out", hl_out, m.hl);
                        check("f_we", f_we, m.fwe);
                        if (m.fwe) check("f_out", f_out, m.f);
                        if (m.lat > 0) check("done_latency", cyc - io_done_cyc, m.lat);
                    end
                end
            end
        end
    end

    // I/O bus-cycle responder with programmable wait states; abandons the cycle on reset.
    logic [15:0] hold_addr;
    logic [1:0]  hold_type;
    logic [7:0]  hold_wdata;
    logic        aborted;
    always begin
        @(negedge clk);
        if (io_activate && nRESET) begin
            hold_addr  = io_addr;
            hold_type  = {io_rd, io_wr};
            hold_wdata = io_wdata;
            aborted    = 1'b0;
            for (int w = 0; w < io_wait; w++) begin
                @(negedge clk);
                if (!nRESET) aborted = 1'b1;
                if (!aborted) begin
                    check("io_addr_hold", io_addr, hold_addr);
                    check("io_type_hold", {io_rd, io_wr}, hold_type);
                    check("io_wdata_hold", io_wdata, hold_wdata);
                end
            end
            if (!aborted) begin
                @(posedge clk);
                #1;
                io_done = 1'b1;
                if (io_data_q.size() > 0) io_rdata = io_data_q.pop_front();
                else                      io_rdata = 8'h00;
                @(posedge clk);
                #1;
                io_done  = 1'b0;
                io_rdata = 8'h00;
            end
        end
    end

    // Memory responder: completes one cycle after the request.
    logic mem_is_wr;
    always begin
        @(negedge clk);
        if (mem_req && nRESET) begin
            mem_is_wr = mem_wr;
            @(posedge clk);
            #1;
            mem_done = 1'b1;
            if (!mem_is_wr && mem_data_q.size() > 0) mem_rdata = mem_data_q.pop_front();
            else                                     mem_rdata = 8'h00;
            @(posedge clk);
            #1;
            mem_done  = 1'b0;
            mem_rdata = 8'h00;
        end
    end

    task automatic start_op(input logic [1:0] o, input logic b, input logic d, input logic r,
                            input logic [7:0] a, input logic [7:0] n, input logic [7:0] w,
                            input logic [7:0] f, input logic [15:0] bc, input logic [15:0] hl);
        @(posedge clk);
        #1;
        op = o; blk = b; dec = d; rep = r;
        a_in = a; n_in = n; wval_in = w; f_in = f; bc_in = bc; hl_in = hl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int n = 0; n < 5000 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_seen", got, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [95:0] all_outs();
        return {io_activate, io_rd, io_wr, io_addr, io_wdata, mem_req, mem_wr, mem_addr, mem_wdata,
                busy, done, rdata, b_out, hl_out, f_out, f_we};
    endfunction

    initial begin
        #12;
        check("reset_outputs", all_outs(), 96'h0);
        #10;
        nRESET = 1'b1;

        test_name = "in_n";
        io_wait = 0;
        push_io(16'h1234, 1'b1, 1'b0, 8'h00);
        io_data_q.push_back(8'hFE);
        push_done(8'hFE, 1'b1, 8'hAB, 16'h1111, 8'h00, 1'b0, 2);
        start_op(2'd0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00, 8'hFF, 16'hABCD, 16'h1111);
        check("start_to_activate", io_activate, 1'b1);
        wait_done();

        test_name = "in_c";
        push_io(16'h5678, 1'b1, 1'b0, 8'h00);
        io_data_q.push_back(8'h00);
        push_done(8'h00, 1'b1, 8'h56, 16'h2222, 8'h45, 1'b1, 2);
        start_op(2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 16'h5678, 16'h2222);
        wait_done();

        test_name = "out_c";
        io_wait = 3;
        push_io(16'h0110, 1'b0, 1'b1, 8'h67);
        push_done(8'h00, 1'b0, 8'h01, 16'h3333, 8'h00, 1'b0, 2);
        start_op(2'd3, 1'b0, 1'b0, 1'b0, 8'h99, 8'h00, 8'h67, 8'h00, 16'h0110, 16'h3333);
        @(posedge clk);
        #1;
        op = 2'd0; a_in = 8'h55; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_mid", busy, 1'b1);
        wait_done();

        test_name = "out_n";
        io_wait = 1;
        push_io(16'h9A7E, 1'b0, 1'b1, 8'h9A);
        push_done(8'h00, 1'b0, 8'h44, 16'h4444, 8'h00, 1'b0, 2);
        start_op(2'd2, 1'b0, 1'b0, 1'b0, 8'h9A, 8'h7E, 8'h31, 8'h00, 16'h4400, 16'h4444);
        wait_done();

        test_name = "inir";
        io_wait = 0;
        push_io(16'h0210, 1'b1, 1'b0, 8'h00);
        push_mem(16'h4000, 1'b1, 8'h11);
        push_io(16'h0110, 1'b1, 1'b0, 8'h00);
        push_mem(16'h4001, 1'b1, 8'h22);
        io_data_q.push_back(8'h11);
        io_data_q.push_back(8'h22);
        push_done(8'h22, 1'b1, 8'h00, 16'h4002, 8'h6B, 1'b1, 0);
        start_op(2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h29, 16'h0210, 16'h4000);
        wait_done();

        test_name = "otdr";
        push_mem(16'h0000, 1'b0, 8'h00);
        mem_data_q.push_back(8'hA5);
        push_io(16'h0020, 1'b0, 1'b1, 8'hA5);
        push_done(8'h00, 1'b0, 8'h00, 16'hFFFF, 8'h42, 1'b1, 0);
        start_op(2'd2, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0120, 16'h0000);
        wait_done();

        test_name = "reset_mid";
        io_wait = 10;
        push_io(16'h0210, 1'b1, 1'b0, 8'h00);
        start_op(2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0210, 16'h4000);
        @(posedge clk);
        @(posedge clk);
        #2;
        nRESET = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 96'h0);
        repeat (3) @(posedge clk);
        #2;
        nRESET = 1'b1;
        exp_q.delete();
        io_data_q.delete();
        begin
            int act0;
            act0 = act_cnt;
            repeat (20) @(posedge clk);
            check("no_activate_after_reset", act_cnt - act0, 0);
        end
        @(negedge clk);
        check("idle_after_reset", busy, 1'b0);

        test_name = "inir_b0_wrap";
        io_wait = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] bv, dv;
            bv = 8'(0 - i);
            dv = 8'(i) ^ 8'h5A;
            push_io({bv, 8'h33}, 1'b1, 1'b0, 8'h00);
            io_data_q.push_back(dv);
            push_mem(16'(32'hFFFF + i), 1'b1, dv);
        end
        push_done(8'hA5, 1'b1, 8'h00, 16'h00FF, 8'h42, 1'b1, 0);
        start_op(2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h80, 16'h0033, 16'hFFFF);
        wait_done();

        test_name = "end";
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout in %s", test_name);
        $fatal(1, "watchdog");
    end

endmodule
